// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory bus arbiter.
package mem_bus_pkg;
  typedef enum logic [2:0] {IDLE, IC_ISSUE, IC_WAIT, DC_ISSUE, DC_WAIT} state_e;

  localparam int WORD_BYTES = 4;
  localparam int WORD_SHIFT = $clog2(WORD_BYTES);

  localparam logic REQ_IC = 1'b0;
  localparam logic REQ_DC = 1'b1;
endpackage

// File: rtl/arb2_pick.sv
// Two-way requester picker. ARB_ROUND_ROBIN_EN selects round-robin tie break;
// otherwise dcache wins every tie.
module arb2_pick
  import mem_bus_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       winner
);
  // With no request the winner is a don't-care; holding last_grant keeps it stable.
  always_comb begin
    winner = last_grant;
    if (req[REQ_DC] && req[REQ_IC]) begin
`ifdef ARB_ROUND_ROBIN_EN
      winner = ~last_grant;
`else
      winner = REQ_DC;
`endif
    end else if (req[REQ_DC]) begin
      winner = REQ_DC;
    end else if (req[REQ_IC]) begin
      winner = REQ_IC;
    end
  end
endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between icache line refills and dcache word accesses.
// Define ARB_ROUND_ROBIN_EN for round-robin ties; default is dcache priority.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int BURST_LEN = 4,
  parameter int ADDR_W    = 64
) (
  input  logic              CLK,
  input  logic              reset_n,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_gnt,
  output logic              ic_rvalid,
  output logic [31:0]       ic_rdata,
  output logic              ic_done,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [31:0]       dc_wdata,
  output logic              dc_gnt,
  output logic              dc_rvalid,
  output logic [31:0]       dc_rdata,
  output logic              dc_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);
  localparam int BEAT_W = $clog2(BURST_LEN);
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(BURST_LEN * WORD_BYTES - 1);
  localparam logic [ADDR_W-1:0] WORD_MASK = ADDR_W'(WORD_BYTES - 1);

  state_e              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d, beat_nxt;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                mem_we_q, mem_we_d;
  logic                ic_gnt_q, ic_gnt_d;
  logic                dc_gnt_q, dc_gnt_d;
  logic                last_grant, winner;
  logic                ic_beat_ok, dc_rd_ok, dc_wr_ok, last_beat;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_q, last_d;
  assign last_grant = last_q;
`else
  assign last_grant = REQ_IC;
`endif

  arb2_pick u_pick (
    .req       ({dc_req, ic_req}),
    .last_grant(last_grant),
    .winner    (winner)
  );

  // A beat is accepted either in WAIT or, for zero-latency memory, in the ack cycle.
  assign ic_beat_ok = (state_q == IC_WAIT && mem_rvalid) ||
                      (state_q == IC_ISSUE && mem_ack && mem_rvalid);
  assign dc_rd_ok   = (state_q == DC_WAIT && mem_rvalid) ||
                      (state_q == DC_ISSUE && mem_ack && !mem_we_q && mem_rvalid);
  assign dc_wr_ok   = state_q == DC_ISSUE && mem_ack && mem_we_q;
  assign last_beat  = beat_q == BEAT_W'(BURST_LEN - 1);
  assign beat_nxt   = beat_q + BEAT_W'(1);

  assign ic_gnt    = ic_gnt_q;
  assign ic_rvalid = ic_beat_ok;
  assign ic_rdata  = ic_beat_ok ? mem_rdata : '0;
  assign ic_done   = ic_beat_ok && last_beat;
  assign dc_gnt    = dc_gnt_q;
  assign dc_rvalid = dc_rd_ok;
  assign dc_rdata  = dc_rd_ok ? mem_rdata : '0;
  assign dc_done   = dc_rd_ok || dc_wr_ok;
  assign mem_req   = (state_q == IC_ISSUE) || (state_q == DC_ISSUE);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    base_d      = base_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = mem_we_q;
    ic_gnt_d    = 1'b0;
    dc_gnt_d    = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    last_d      = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (ic_req || dc_req) begin
`ifdef ARB_ROUND_ROBIN_EN
          last_d = winner;
`endif
          if (winner == REQ_DC) begin
            state_d     = DC_ISSUE;
            dc_gnt_d    = 1'b1;
            mem_addr_d  = dc_addr & ~WORD_MASK;
            mem_we_d    = dc_we;
            mem_wdata_d = dc_wdata;
          end else begin
            state_d    = IC_ISSUE;
            ic_gnt_d   = 1'b1;
            base_d     = ic_addr & ~LINE_MASK;
            mem_addr_d = ic_addr & ~LINE_MASK;
            mem_we_d   = 1'b0;
            beat_d     = '0;
          end
        end
      end
      IC_ISSUE: if (mem_ack && !mem_rvalid) state_d = IC_WAIT;
      IC_WAIT:  ;
      DC_ISSUE: if (mem_ack) state_d = (mem_we_q || mem_rvalid) ? IDLE : DC_WAIT;
      DC_WAIT:  if (mem_rvalid) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    // Beat offset is ORed into the line base, so the address never leaves the line.
    if (ic_beat_ok) begin
      if (last_beat) begin
        state_d = IDLE;
        beat_d  = '0;
      end else begin
        state_d    = IC_ISSUE;
        beat_d     = beat_nxt;
        mem_addr_d = base_q | (ADDR_W'(beat_nxt) << WORD_SHIFT);
      end
    end
    if (dc_done) mem_we_d = 1'b0;
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      base_q      <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      ic_gnt_q    <= 1'b0;
      dc_gnt_q    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q      <= REQ_IC;
`endif
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      base_q      <= base_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      ic_gnt_q    <= ic_gnt_d;
      dc_gnt_q    <= dc_gnt_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_q      <= last_d;
`endif
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter (BURST_LEN=4, ADDR_W=64).
module tb_mem_bus_arbiter;
  logic        CLK = 1'b0;
  logic        reset_n;
  logic        ic_req, dc_req, dc_we, mem_ack, mem_rvalid;
  logic [63:0] ic_addr, dc_addr, mem_addr;
  logic [31:0] dc_wdata, mem_rdata, ic_rdata, dc_rdata, mem_wdata;
  logic        ic_gnt, ic_rvalid, ic_done, dc_gnt, dc_rvalid, dc_done, mem_req, mem_we;
  int          checks = 0;
  int          failures = 0;

  mem_bus_arbiter #(.BURST_LEN(4), .ADDR_W(64)) dut (
    .CLK(CLK), .reset_n(reset_n),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_gnt(ic_gnt), .ic_rvalid(ic_rvalid),
    .ic_rdata(ic_rdata), .ic_done(ic_done),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_gnt(dc_gnt), .dc_rvalid(dc_rvalid), .dc_rdata(dc_rdata), .dc_done(dc_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic clear_inputs();
    ic_req = 0; ic_addr = '0; dc_req = 0; dc_we = 0; dc_addr = '0; dc_wdata = '0;
    mem_ack = 0; mem_rvalid = 0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    reset_n = 0; clear_inputs();
    tick(); tick();
    reset_n = 1;
  endtask

  // Answers memory requests until a done pulse; zl selects zero-latency reads.
  task automatic serve(input bit zl, output int ncyc, output bit seen);
    bit icd, dcd;
    seen = 0; ncyc = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (mem_req) begin mem_ack = 1; mem_rvalid = zl && !mem_we; end
      else begin mem_ack = 0; mem_rvalid = 1; end
      mem_rdata = 32'h5500_0000 + i;
      #1;
      icd = ic_done; dcd = dc_done; seen = icd || dcd;
      tick();
      mem_ack = 0; mem_rvalid = 0; ncyc++;
      if (icd) ic_req = 0;
      if (dcd) dc_req = 0;
    end
  endtask

  task automatic test_reset();
    reset_n = 0; clear_inputs();
    mem_rvalid = 1; mem_rdata = 32'hFFFF_FFFF; mem_ack = 1;
    #3;
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
    checks++; if (mem_addr !== 64'h0) begin failures++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin failures++; $display("FAIL reset_mem_wdata got=%h exp=0", mem_wdata); end
    checks++; if ({ic_gnt, ic_rvalid, ic_done, dc_gnt, dc_rvalid, dc_done, mem_we} !== 7'b0) begin
      failures++; $display("FAIL reset_ctl got=%b exp=0000000", {ic_gnt, ic_rvalid, ic_done, dc_gnt, dc_rvalid, dc_done, mem_we}); end
    checks++; if ({ic_rdata, dc_rdata} !== 64'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", {ic_rdata, dc_rdata}); end
    tick(); tick();
    reset_n = 1; mem_ack = 0;
    tick();
    // Stray rvalid in IDLE is ignored.
    checks++; if ({ic_rvalid, dc_rvalid, mem_req} !== 3'b0) begin failures++; $display("FAIL stray_rvalid got=%b exp=000", {ic_rvalid, dc_rvalid, mem_req}); end
    mem_rvalid = 0;
  endtask

  task automatic test_ic_refill();
    do_reset();
    ic_req = 1; ic_addr = 64'h1236;
    tick();
    checks++; if ({ic_gnt, dc_gnt, mem_req, mem_we} !== 4'b1010) begin failures++; $display("FAIL ic_grant got=%b exp=1010", {ic_gnt, dc_gnt, mem_req, mem_we}); end
    ic_addr = 64'hFFFF;
    for (int k = 0; k < 4; k++) begin
      checks++; if (mem_addr !== 64'h1230 + 4 * k || mem_req !== 1'b1) begin
        failures++; $display("FAIL ic_beat_addr k=%0d got=%h req=%b exp=%h", k, mem_addr, mem_req, 64'h1230 + 4 * k); end
      mem_ack = 1; #1;
      checks++; if (ic_rvalid !== 1'b0) begin failures++; $display("FAIL ic_early_rvalid k=%0d got=%b exp=0", k, ic_rvalid); end
      tick(); mem_ack = 0; mem_rvalid = 1; mem_rdata = 32'hA000_0000 + k; #1;
      checks++; if ({mem_req, ic_rvalid, ic_done} !== {2'b01, k == 3} || ic_rdata !== 32'hA000_0000 + k) begin
        failures++; $display("FAIL ic_beat_data k=%0d got=%b/%h exp=%b/%h", k, {mem_req, ic_rvalid, ic_done}, ic_rdata, {2'b01, k == 3}, 32'hA000_0000 + k); end
      tick(); mem_rvalid = 0;
    end
    ic_req = 0;
    checks++; if ({mem_req, ic_gnt} !== 2'b00) begin failures++; $display("FAIL ic_after_done got=%b exp=00", {mem_req, ic_gnt}); end
  endtask

  task automatic test_dc_write();
    dc_req = 1; dc_we = 1; dc_addr = 64'h2002; dc_wdata = 32'hDEAD_BEEF;
    tick();
    dc_wdata = 32'h0; dc_addr = 64'h0;
    checks++; if ({dc_gnt, ic_gnt, mem_req, mem_we} !== 4'b1011 || mem_addr !== 64'h2000 || mem_wdata !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL dc_write_issue got=%b/%h/%h exp=1011/2000/deadbeef", {dc_gnt, ic_gnt, mem_req, mem_we}, mem_addr, mem_wdata); end
    mem_ack = 1; #1;
    checks++; if ({dc_done, dc_rvalid} !== 2'b10) begin failures++; $display("FAIL dc_write_done got=%b exp=10", {dc_done, dc_rvalid}); end
    tick(); mem_ack = 0; dc_req = 0; dc_we = 0;
    checks++; if ({mem_req, dc_gnt, dc_done} !== 3'b000) begin failures++; $display("FAIL dc_write_after got=%b exp=000", {mem_req, dc_gnt, dc_done}); end
  endtask

  task automatic test_tie();
    int n; bit seen;
    do_reset();
    ic_req = 1; ic_addr = 64'h4000; dc_req = 1; dc_we = 1; dc_addr = 64'h5000; dc_wdata = 32'h1;
    tick();
    checks++; if ({ic_gnt, dc_gnt} !== 2'b01) begin failures++; $display("FAIL tie1 got=%b exp=01", {ic_gnt, dc_gnt}); end
    serve(1, n, seen);
    checks++; if ({seen, ic_gnt, dc_gnt} !== 3'b100) begin failures++; $display("FAIL tie1_done got=%b exp=100", {seen, ic_gnt, dc_gnt}); end
    tick();
    checks++; if ({ic_gnt, dc_gnt} !== 2'b10) begin failures++; $display("FAIL tie1_second got=%b exp=10", {ic_gnt, dc_gnt}); end
    serve(1, n, seen);
    ic_req = 1; dc_req = 1;
    tick();
    checks++; if ({seen, ic_gnt, dc_gnt} !== 3'b101) begin failures++; $display("FAIL tie2 got=%b exp=101", {seen, ic_gnt, dc_gnt}); end
    serve(1, n, seen);
    tick();
    checks++; if ({ic_gnt, dc_gnt} !== 2'b10) begin failures++; $display("FAIL tie2_second got=%b exp=10", {ic_gnt, dc_gnt}); end
    serve(1, n, seen);
    // dcache re-requests right after its own grant completes, so last grant is dcache.
    ic_req = 1; dc_req = 1;
    tick();
    serve(1, n, seen);
    dc_req = 1;
    tick();
`ifdef ARB_ROUND_ROBIN_EN
    checks++; if ({ic_gnt, dc_gnt} !== 2'b10) begin failures++; $display("FAIL tie_after_dc got=%b exp=10", {ic_gnt, dc_gnt}); end
`else
    checks++; if ({ic_gnt, dc_gnt} !== 2'b01) begin failures++; $display("FAIL tie_after_dc got=%b exp=01", {ic_gnt, dc_gnt}); end
`endif
    serve(1, n, seen);
    tick();
    serve(1, n, seen);
    checks++; if ({seen, ic_req, dc_req} !== 3'b100) begin failures++; $display("FAIL tie_drain got=%b exp=100", {seen, ic_req, dc_req}); end
  endtask

  task automatic test_zero_latency();
    ic_req = 1; ic_addr = 64'h7FFC;
    tick();
    for (int k = 0; k < 4; k++) begin
      checks++; if (mem_req !== 1'b1 || mem_addr !== 64'h7FF0 + 4 * k) begin
        failures++; $display("FAIL zl_addr k=%0d got=%b/%h exp=1/%h", k, mem_req, mem_addr, 64'h7FF0 + 4 * k); end
      mem_ack = 1; mem_rvalid = 1; mem_rdata = 32'hB000_0000 + k; #1;
      checks++; if ({ic_rvalid, ic_done} !== {1'b1, k == 3} || ic_rdata !== 32'hB000_0000 + k) begin
        failures++; $display("FAIL zl_data k=%0d got=%b/%h exp=%b/%h", k, {ic_rvalid, ic_done}, ic_rdata, {1'b1, k == 3}, 32'hB000_0000 + k); end
      tick(); mem_ack = 0; mem_rvalid = 0;
    end
    ic_req = 0;
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL zl_end got=%b exp=0", mem_req); end
  endtask

  task automatic test_reset_mid_refill();
    int n; bit seen;
    ic_req = 1; ic_addr = 64'h1230;
    tick();
    for (int k = 0; k < 2; k++) begin
      mem_ack = 1; tick(); mem_ack = 0; mem_rvalid = 1; tick(); mem_rvalid = 0;
    end
    checks++; if (mem_req !== 1'b1 || mem_addr !== 64'h1238) begin failures++; $display("FAIL rst_beat2 got=%b/%h exp=1/1238", mem_req, mem_addr); end
    reset_n = 0; mem_rvalid = 1; mem_ack = 1; #1;
    checks++; if ({mem_req, ic_done, ic_rvalid} !== 3'b000) begin failures++; $display("FAIL rst_async got=%b exp=000", {mem_req, ic_done, ic_rvalid}); end
    tick(); mem_rvalid = 0; mem_ack = 0;
    reset_n = 1;
    tick();
    checks++; if ({mem_req, ic_gnt} !== 2'b11 || mem_addr !== 64'h1230) begin failures++; $display("FAIL rst_fresh got=%b/%h exp=11/1230", {mem_req, ic_gnt}, mem_addr); end
    serve(0, n, seen);
    checks++; if (seen !== 1'b1 || n !== 8) begin failures++; $display("FAIL rst_refill got=%b/%0d exp=1/8", seen, n); end
  endtask

  task automatic test_back_to_back();
    ic_req = 1; ic_addr = 64'h8000;
    tick();
    for (int k = 0; k < 4; k++) begin
      if (k == 0) begin dc_req = 1; dc_we = 0; dc_addr = 64'h9004; end
      mem_ack = 1; tick(); mem_ack = 0;
      checks++; if (dc_gnt !== 1'b0) begin failures++; $display("FAIL b2b_no_gnt_a k=%0d got=%b exp=0", k, dc_gnt); end
      mem_rvalid = 1; #1;
      checks++; if (ic_done !== (k == 3)) begin failures++; $display("FAIL b2b_ic_done k=%0d got=%b exp=%b", k, ic_done, k == 3); end
      tick(); mem_rvalid = 0;
    end
    ic_req = 0;
    checks++; if ({dc_gnt, mem_req} !== 2'b00) begin failures++; $display("FAIL b2b_idle got=%b exp=00", {dc_gnt, mem_req}); end
    tick();
    checks++; if ({dc_gnt, mem_req, mem_we} !== 3'b110 || mem_addr !== 64'h9004) begin
      failures++; $display("FAIL b2b_dc_gnt got=%b/%h exp=110/9004", {dc_gnt, mem_req, mem_we}, mem_addr); end
    mem_ack = 1; #1;
    checks++; if ({dc_done, dc_rvalid} !== 2'b00) begin failures++; $display("FAIL dc_read_ack got=%b exp=00", {dc_done, dc_rvalid}); end
    tick(); mem_ack = 0; mem_rvalid = 1; mem_rdata = 32'hCAFE_F00D; #1;
    checks++; if ({dc_done, dc_rvalid} !== 2'b11 || dc_rdata !== 32'hCAFE_F00D) begin
      failures++; $display("FAIL dc_read_data got=%b/%h exp=11/cafef00d", {dc_done, dc_rvalid}, dc_rdata); end
    tick(); mem_rvalid = 0; dc_req = 0;
  endtask

  initial begin
    reset_n = 0; clear_inputs();
    test_reset();
    test_ic_refill();
    test_dc_write();
    test_tie();
    test_zero_latency();
    test_reset_mid_refill();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the single memory bus port between instruction-cache line refills and data-cache word accesses. Picks one requester at a time and sequences the memory transactions for it. An icache refill becomes BURST_LEN consecutive word reads. A dcache access becomes one word read or one word write. The block sits between both caches and the memory bus.

## Interface
Parameters:
- BURST_LEN, default 4: words per icache line. Must be a power of two, at least 2. 4 words gives the current 16-byte line.
- ADDR_W, default 64: address width.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ic_req  in  1  icache refill request; held high until ic_done.
- ic_addr  in  ADDR_W  any address inside the line to fill.
- ic_gnt  out  1  one-cycle pulse: refill accepted.
- ic_rvalid  out  1  one refill word is valid this cycle.
- ic_rdata  out  32  refill word, delivered in beat order 0..BURST_LEN-1.
- ic_done  out  1  one-cycle pulse, coincident with the last ic_rvalid.
- dc_req  in  1  dcache request; held high until dc_done.
- dc_we  in  1  1 = write, 0 = read.
- dc_addr  in  ADDR_W  word address; bits [1:0] are ignored.
- dc_wdata  in  32  write data.
- dc_gnt  out  1  one-cycle pulse: access accepted.
- dc_rvalid  out  1  read data valid this cycle.
- dc_rdata  out  32  read data.
- dc_done  out  1  one-cycle pulse: access complete.
- mem_req  out  1  memory request; held with stable address and data until mem_ack.
- mem_we  out  1  write enable.
- mem_addr  out  ADDR_W  word-aligned address.
- mem_wdata  out  32  write data.
- mem_ack  in  1  request accepted. For a write, the write is complete.
- mem_rvalid  in  1  read data return; at most one read is outstanding.
- mem_rdata  in  32  read data.

## Operation
- States:
  - IDLE
  - IC_ISSUE (mem_req high for beat k)
  - IC_WAIT (waiting for mem_rvalid of beat k)
  - DC_ISSUE
  - DC_WAIT (reads only)
- Arbitration is evaluated only in IDLE.
  - Exactly one request high: that requester wins.
  - Both high: resolved per Configuration.
- Line base is ic_addr with bits [log2(BURST_LEN*4)-1:0] cleared. It is latched at grant.
- Beat k address is base + 4k. The add never carries past the line, so there is no wrap into the next line.
- Beat counter is log2(BURST_LEN) bits.
  - At beat k = BURST_LEN-1 with mem_rvalid: go to IDLE.
  - Otherwise: increment k and return to IC_ISSUE.
- dcache write completes on mem_ack: DC_ISSUE → IDLE, dc_done pulses that cycle.
- dcache read: DC_ISSUE → DC_WAIT on mem_ack. DC_WAIT → IDLE on mem_rvalid.
- mem_ack and mem_rvalid in the same cycle (zero-latency read): the beat completes and the WAIT state is skipped.
- mem_rvalid outside IC_WAIT or DC_WAIT (and outside that same-cycle ack case) is ignored.
- Requester inputs (addr, we, wdata) are sampled at grant. Later changes have no effect.

## Timing
- Reset values:
  - State IDLE, beat count 0.
  - All outputs 0, including mem_addr, mem_wdata, ic_rdata and dc_rdata.
  - Last-grant register is "icache", so the first tie goes to dcache.
- Grant latency: request seen in IDLE at edge N → gnt pulse and mem_req high in cycle N+1.
- Read data: ic_rvalid/dc_rvalid and rdata are combinational pass-throughs of mem_rvalid/mem_rdata in the accepting cycle.
- Done pulses fire in the same cycle as the final rvalid, or the mem_ack for a write.
- Back-to-back: the first cycle after a done is IDLE. The next grant is therefore no earlier than 2 cycles after done.
- reset_n asserted mid-transaction:
  - mem_req drops immediately (asynchronously) and the partial line is discarded.
  - No done pulse is produced.
  - The memory must tolerate an abandoned request.

## Configuration
- ARB_ROUND_ROBIN_EN defined: a tie goes to the requester not granted last. The last-grant register updates at every grant.
- ARB_ROUND_ROBIN_EN undefined: fixed priority, dcache always wins ties. The last-grant register is not built.

## Structure
- Shared package mem_bus_pkg:
  - state enum
  - WORD_BYTES = 4
  - requester ID encoding (REQ_IC = 0, REQ_DC = 1)
- One sub-module, arb2_pick: combinational two-way picker taking req[1:0] and last_grant and returning the winner. It contains the ARB_ROUND_ROBIN_EN conditional.

## Test plan
- Lone icache refill, ic_addr = 0x1236, mem latency 1 → mem_addr 0x1230, 0x1234, 0x1238, 0x123C in order; four ic_rvalid with matching data; ic_done on the 4th.
- dcache write: addr 0x2002, data 0xDEADBEEF → mem_we = 1, mem_addr 0x2000; dc_done in the mem_ack cycle; no dc_rvalid.
- ic_req and dc_req raised in the same cycle, twice in a row:
  - round-robin build: dcache then icache, then dcache then icache again.
  - fixed build: dcache first both times.
- Zero-latency memory (mem_ack and mem_rvalid together) → refill completes in BURST_LEN issue cycles with no WAIT states.
- reset_n pulsed low during beat 2 of a refill → mem_req 0 immediately, no ic_done; a fresh refill after reset starts at beat 0.
- dc_req raised mid-refill → no dc_gnt until after ic_done; dc_gnt arrives 2 cycles after ic_done.
